// File: rtl/uart_buffered.sv
// uart_buffered: byte-oriented UART with a transmit FIFO and a receive FIFO
// behind one-cycle request/acknowledge ports.
//
// Ports
//   clk, reset            posedge clock; asynchronous active-high reset
//   uart_in_data/valid    write request (push into tx FIFO)
//   uart_in_ready         one-cycle write acknowledge
//   uart_out_valid        read request (pop from rx FIFO)
//   uart_out_data/ready   registered popped byte and one-cycle acknowledge
//   uart_rx / uart_tx     serial lines, idle high
//   lost                  sticky receive-overflow flag
//   busy                  tx FIFO non-empty or frame in progress
//   recv_/trans_buffer_length  registered FIFO occupancies
//
// Build option: define UART_LOOPBACK_EN to feed the receiver from uart_tx
// internally; uart_rx is then ignored.
module uart_buffered #(
  parameter int BUF_WIDTH    = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int STOP_CLKS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           uart_in_data,
  input  logic                 uart_in_valid,
  output logic                 uart_in_ready,
  input  logic                 uart_out_valid,
  output logic [7:0]           uart_out_data,
  output logic                 uart_out_ready,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic                 lost,
  output logic                 busy,
  output logic [BUF_WIDTH-1:0] recv_buffer_length,
  output logic [BUF_WIDTH-1:0] trans_buffer_length
);
  localparam int DEPTH = 2 ** BUF_WIDTH;
  localparam int CW = $clog2(STOP_CLKS + CLKS_PER_BIT + 1);
  localparam logic [BUF_WIDTH-1:0] FULL = {BUF_WIDTH{1'b1}};
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  // ---------------- transmit FIFO ----------------
  logic [7:0]           tx_mem [DEPTH];
  logic [BUF_WIDTH-1:0] tx_wr_q, tx_rd_q, tx_cnt_q, tx_cnt_d;
  logic                 tx_push, tx_pop, tx_empty;

  assign tx_push  = uart_in_valid && (tx_cnt_q != FULL);
  assign tx_empty = (tx_cnt_q == '0);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + BUF_WIDTH'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - BUF_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= uart_in_data;
  end

  // ---------------- transmit FSM ----------------
  tx_state_t      tx_state_q, tx_state_d;
  logic [CW-1:0]  tx_clk_q, tx_clk_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_clk_d   = tx_clk_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rd_q];
          tx_state_d = TX_START;
          tx_clk_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_clk_q == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_clk_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_clk_d = tx_clk_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_clk_q == BIT_LAST) begin
          tx_clk_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_clk_d = tx_clk_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_clk_q == STOP_LAST) begin
          tx_clk_d = '0;
          // Back-to-back frames: go straight into the next start bit.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rd_q];
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_clk_d = tx_clk_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------- receive path ----------------
  logic rx_src, rx_s1_q, rx_s2_q, rx_prev_q;
`ifdef UART_LOOPBACK_EN
  logic unused_uart_rx;
  assign unused_uart_rx = uart_rx;
  assign rx_src = tx_q;
`else
  assign rx_src = uart_rx;
`endif

  logic [7:0]           rx_mem [DEPTH];
  logic [BUF_WIDTH-1:0] rx_wr_q, rx_rd_q, rx_cnt_q, rx_cnt_d;
  logic                 rx_push, rx_write, rx_pop;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_clk_q, rx_clk_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;

  assign rx_write = rx_push && (rx_cnt_q != FULL);
  assign rx_pop   = uart_out_valid && (rx_cnt_q != '0);

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_write && !rx_pop)      rx_cnt_d = rx_cnt_q + BUF_WIDTH'(1);
    else if (!rx_write && rx_pop) rx_cnt_d = rx_cnt_q - BUF_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rx_write) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_clk_d   = rx_clk_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_clk_d   = '0;
          rx_shift_d = '0;
        end
      end
      RX_START: begin
        // Half a bit after the edge: a glitch has returned high by now.
        if (rx_clk_q == HALF_LAST) begin
          rx_clk_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_clk_d = rx_clk_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_clk_q == BIT_LAST) begin
          rx_clk_d   = '0;
          rx_shift_d = rx_shift_q >> 1;
          rx_shift_d[DATA_BITS-1] = rx_s2_q;
          if (rx_bit_q == DATA_LAST) rx_state_d = RX_STOP;
          else                       rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_clk_d = rx_clk_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_clk_q == BIT_LAST) begin
          rx_clk_d   = '0;
          rx_push    = rx_s2_q;  // low stop bit is a framing error: drop byte
          rx_state_d = rx_s2_q ? RX_IDLE : RX_WAITHI;
        end else begin
          rx_clk_d = rx_clk_q + CW'(1);
        end
      end
      RX_WAITHI: if (rx_s2_q) rx_state_d = RX_IDLE;
      default:   rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- control registers ----------------
  logic [7:0] out_data_q;
  logic       in_ready_q, out_ready_q, lost_q, busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q <= '0; tx_rd_q <= '0; tx_cnt_q <= '0;
      rx_wr_q <= '0; rx_rd_q <= '0; rx_cnt_q <= '0;
      tx_state_q <= TX_IDLE; tx_clk_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0;
      tx_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_clk_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      out_data_q <= '0; in_ready_q <= 1'b0; out_ready_q <= 1'b0;
      lost_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      if (tx_push)  tx_wr_q <= tx_wr_q + BUF_WIDTH'(1);
      if (tx_pop)   tx_rd_q <= tx_rd_q + BUF_WIDTH'(1);
      if (rx_write) rx_wr_q <= rx_wr_q + BUF_WIDTH'(1);
      if (rx_pop)   rx_rd_q <= rx_rd_q + BUF_WIDTH'(1);
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_state_q <= tx_state_d; tx_clk_q <= tx_clk_d;
      tx_bit_q <= tx_bit_d; tx_shift_q <= tx_shift_d; tx_q <= tx_d;
      rx_state_q <= rx_state_d; rx_clk_q <= rx_clk_d;
      rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d;
      rx_s1_q <= rx_src; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
      if (rx_pop) out_data_q <= rx_mem[rx_rd_q];
      out_ready_q <= rx_pop;
      in_ready_q  <= tx_push;
      if (rx_push && (rx_cnt_q == FULL)) lost_q <= 1'b1;
      busy_q <= (tx_cnt_d != '0) || (tx_state_d != TX_IDLE);
    end
  end

  assign uart_tx             = tx_q;
  assign uart_in_ready       = in_ready_q;
  assign uart_out_ready      = out_ready_q;
  assign uart_out_data       = out_data_q;
  assign lost                = lost_q;
  assign busy                = busy_q;
  assign recv_buffer_length  = rx_cnt_q;
  assign trans_buffer_length = tx_cnt_q;
endmodule

// File: tb/tb_uart_buffered.sv
module tb_uart_buffered;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instances A and B are cross-wired; C (BUF_WIDTH=2) is fed by the bench.
  logic [7:0]  a_in_data, a_out_data, b_in_data, b_out_data, c_in_data, c_out_data;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_tx, a_lost, a_busy;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_tx, b_lost, b_busy;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_tx, c_rx, c_lost, c_busy;
  logic [15:0] a_rlen, a_tlen, b_rlen, b_tlen;
  logic [1:0]  c_rlen, c_tlen;

  uart_buffered #(.BUF_WIDTH(16), .CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_CLKS(8)) u_a (
    .clk(clk), .reset(reset), .uart_in_data(a_in_data), .uart_in_valid(a_in_valid),
    .uart_in_ready(a_in_ready), .uart_out_valid(a_out_valid), .uart_out_data(a_out_data),
    .uart_out_ready(a_out_ready), .uart_rx(b_tx), .uart_tx(a_tx), .lost(a_lost),
    .busy(a_busy), .recv_buffer_length(a_rlen), .trans_buffer_length(a_tlen));

  uart_buffered #(.BUF_WIDTH(16), .CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_CLKS(8)) u_b (
    .clk(clk), .reset(reset), .uart_in_data(b_in_data), .uart_in_valid(b_in_valid),
    .uart_in_ready(b_in_ready), .uart_out_valid(b_out_valid), .uart_out_data(b_out_data),
    .uart_out_ready(b_out_ready), .uart_rx(a_tx), .uart_tx(b_tx), .lost(b_lost),
    .busy(b_busy), .recv_buffer_length(b_rlen), .trans_buffer_length(b_tlen));

  uart_buffered #(.BUF_WIDTH(2), .CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_CLKS(8)) u_c (
    .clk(clk), .reset(reset), .uart_in_data(c_in_data), .uart_in_valid(c_in_valid),
    .uart_in_ready(c_in_ready), .uart_out_valid(c_out_valid), .uart_out_data(c_out_data),
    .uart_out_ready(c_out_ready), .uart_rx(c_rx), .uart_tx(c_tx), .lost(c_lost),
    .busy(c_busy), .recv_buffer_length(c_rlen), .trans_buffer_length(c_tlen));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_b(input string tag, input logic [7:0] exp, input logic [15:0] len_after);
    b_out_valid = 1'b1;
    @(negedge clk);
    b_out_valid = 1'b0;
    check({tag, "_ready"}, 32'(b_out_ready), 32'd1);
    check({tag, "_data"}, 32'(b_out_data), 32'(exp));
    check({tag, "_len"}, 32'(b_rlen), 32'(len_after));
    @(negedge clk);
    check({tag, "_ready_drop"}, 32'(b_out_ready), 32'd0);
  endtask

  task automatic read_c(input string tag, input logic [7:0] exp);
    c_out_valid = 1'b1;
    @(negedge clk);
    c_out_valid = 1'b0;
    check({tag, "_ready"}, 32'(c_out_ready), 32'd1);
    check({tag, "_data"}, 32'(c_out_data), 32'(exp));
    @(negedge clk);
  endtask

  task automatic send_c(input logic [7:0] b, input logic stop_bit);
    c_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      c_rx = b[i];
      repeat (4) @(negedge clk);
    end
    c_rx = stop_bit;
    repeat (4) @(negedge clk);
    c_rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  logic [8:0] a5_bits;
  int         n;

  initial begin
    reset = 1'b1;
    a_in_data = '0; a_in_valid = 0; a_out_valid = 0;
    b_in_data = '0; b_in_valid = 0; b_out_valid = 0;
    c_in_data = '0; c_in_valid = 0; c_out_valid = 0; c_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(a_tx), 32'd1);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_tx", 32'(a_tx), 32'd1);
    check("idle_busy", 32'(a_busy), 32'd0);
    check("idle_tlen", 32'(a_tlen), 32'd0);
    check("idle_rlen", 32'(b_rlen), 32'd0);
    check("idle_lost", 32'(a_lost), 32'd0);
    check("idle_ready", 32'(a_in_ready), 32'd0);

    // Single frame 0xA5 out of A: start 0, data LSB first 1,0,1,0,0,1,0,1.
    a_in_data = 8'hA5; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("wr_ready", 32'(a_in_ready), 32'd1);
    check("wr_tlen1", 32'(a_tlen), 32'd1);
    check("wr_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    check("wr_ready_drop", 32'(a_in_ready), 32'd0);
    check("wr_tlen0", 32'(a_tlen), 32'd0);
    a5_bits = 9'b1_0100_1010;  // bit k = line level of serial bit k
    for (int k = 0; k < 44; k++) begin
      if (k < 36) check($sformatf("tx_bit%0d", k / 4), 32'(a_tx), 32'(a5_bits[k / 4]));
      else        check("tx_stop", 32'(a_tx), 32'd1);
      if (k == 43) check("busy_last_stop", 32'(a_busy), 32'd1);
      @(negedge clk);
    end
    check("busy_after_frame", 32'(a_busy), 32'd0);

    // B has received the 0xA5 frame.
    n = 0;
    while (b_rlen != 16'd1 && n < 100) begin @(negedge clk); n++; end
    check("b_rlen_a5", 32'(b_rlen), 32'd1);
    read_b("rd_a5", 8'hA5, 16'd0);

    // Two bytes back to back through the cross-wired link.
    a_in_data = 8'h48; a_in_valid = 1'b1;
    @(negedge clk);
    check("wr48_ready", 32'(a_in_ready), 32'd1);
    a_in_data = 8'h69;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("wr69_ready", 32'(a_in_ready), 32'd1);
    n = 0;
    while ((a_busy || b_rlen != 16'd2) && n < 400) begin @(negedge clk); n++; end
    check("b_rlen2", 32'(b_rlen), 32'd2);
    check("b_lost", 32'(b_lost), 32'd0);
    read_b("rd48", 8'h48, 16'd1);
    read_b("rd69", 8'h69, 16'd0);

    // Read with empty rx FIFO.
    b_out_valid = 1'b1;
    @(negedge clk);
    b_out_valid = 1'b0;
    check("empty_ready", 32'(b_out_ready), 32'd0);
    check("empty_data_hold", 32'(b_out_data), 32'h69);

    // Framing error, then a good frame.
    send_c(8'h5A, 1'b0);
    check("ferr_len", 32'(c_rlen), 32'd0);
    check("ferr_lost", 32'(c_lost), 32'd0);
    send_c(8'h3C, 1'b1);
    check("good_len", 32'(c_rlen), 32'd1);
    read_c("rd3c", 8'h3C);
    check("rd3c_len", 32'(c_rlen), 32'd0);

    // Overflow of the 3-entry rx FIFO.
    send_c(8'h11, 1'b1);
    send_c(8'h22, 1'b1);
    send_c(8'h33, 1'b1);
    check("ovf_lost_before", 32'(c_lost), 32'd0);
    send_c(8'h44, 1'b1);
    check("ovf_len", 32'(c_rlen), 32'd3);
    check("ovf_lost", 32'(c_lost), 32'd1);
    read_c("ovf11", 8'h11);
    read_c("ovf22", 8'h22);
    read_c("ovf33", 8'h33);
    check("ovf_len0", 32'(c_rlen), 32'd0);
    check("ovf_lost_sticky", 32'(c_lost), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
